// File: rtl/skip_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : skip_seq_pkg
// Brief    : Shared constants, state/step enums and step classifier for the
//            skip-sequence code tracker.
// Revision : 1.0  initial release
// ============================================================================
package skip_seq_pkg;

    localparam logic [3:0] CODE_MAX = 4'd13;
    localparam logic [3:0] SKIP_A   = 4'd7;
    localparam logic [3:0] SKIP_B   = 4'd10;
    localparam int         NUM_IDX  = 12;
    localparam logic [3:0] IDX_LAST = 4'(NUM_IDX - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        JUMP = 2'd3
    } step_t;

    // Neighbours are taken modulo NUM_IDX so 11<->0 counts as a single step.
    function automatic step_t classify_step(input logic [3:0] p, input logic [3:0] n);
        logic [3:0] w_up;
        logic [3:0] w_dn;
        w_up = (p == IDX_LAST) ? 4'd0 : p + 4'd1;
        w_dn = (p == 4'd0) ? IDX_LAST : p - 4'd1;
        if (n == p)         return HOLD;
        else if (n == w_up) return UP;
        else if (n == w_dn) return DOWN;
        else                return JUMP;
    endfunction

endpackage
`default_nettype wire

// File: rtl/skip_code_map.sv
`default_nettype none
// ============================================================================
// Module   : skip_code_map
// Brief    : Combinational map from 4-bit skip code to dense ordinal 0..11.
// Revision : 1.0  initial release
// ============================================================================
module skip_code_map
    import skip_seq_pkg::*;
(
    input  logic [3:0] i_code,
    output logic       o_legal,
    output logic [3:0] o_index
);

    // Each skipped code below the sample shifts its ordinal down by one.
    always_comb begin
        o_legal = 1'b1;
        o_index = i_code;
        if (i_code > CODE_MAX || i_code == SKIP_A || i_code == SKIP_B) begin
            o_legal = 1'b0;
            o_index = 4'd0;
        end else if (i_code > SKIP_B) begin
            o_index = i_code - 4'd2;
        end else if (i_code > SKIP_A) begin
            o_index = i_code - 4'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/skip_seq_decoder.sv
`default_nettype none
// ============================================================================
// Module   : skip_seq_decoder
// Brief    : Receive-side tracker: ordinal decode, direction, lock, error
//            pulses and signed lap count for the skip-sequence code.
// Revision : 1.0  initial release
// ============================================================================
module skip_seq_decoder
    import skip_seq_pkg::*;
#(
    parameter int LOCK_LEN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid,
    input  logic [3:0] code,
    output logic [3:0] index,
    output logic       dir,
    output logic       locked,
    output logic       err_code,
    output logic       err_step,
    output logic [7:0] lap
);

    localparam logic [3:0] c_LOCK_LEN = 4'(LOCK_LEN);

    logic       w_legal;
    logic [3:0] w_index;
    step_t      w_step;

    state_t     r_state;
    logic [3:0] r_run;
    logic [3:0] r_index;
    logic       r_dir;
    logic       r_locked;
    logic       r_err_code;
    logic       r_err_step;
    logic [7:0] r_lap;

    skip_code_map u_map (
        .i_code  (code),
        .o_legal (w_legal),
        .o_index (w_index)
    );

    assign w_step = classify_step(r_index, w_index);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_run      <= 4'd0;
            r_index    <= 4'd0;
            r_dir      <= 1'b1;
            r_locked   <= 1'b0;
            r_err_code <= 1'b0;
            r_err_step <= 1'b0;
            r_lap      <= 8'd0;
        end else begin
            r_err_code <= 1'b0;
            r_err_step <= 1'b0;
            if (valid) begin
                if (!w_legal) begin
                    r_err_code <= 1'b1;
                    r_state    <= IDLE;
                    r_run      <= 4'd0;
                    r_locked   <= 1'b0;
                end else if (r_state == IDLE) begin
                    r_state <= TRACK;
                    r_index <= w_index;
                    r_run   <= 4'd0;
                end else begin
                    case (w_step)
                        HOLD: ;
                        UP, DOWN: begin
                            r_index <= w_index;
                            r_dir   <= (w_step == UP);
                            if (w_step == UP && r_index == IDX_LAST)
                                r_lap <= r_lap + 8'd1;
                            else if (w_step == DOWN && r_index == 4'd0)
                                r_lap <= r_lap - 8'd1;
                            // Run only advances while acquiring; once locked it is irrelevant.
                            if (r_state == TRACK) begin
                                r_run <= r_run + 4'd1;
                                if (r_run + 4'd1 == c_LOCK_LEN) begin
                                    r_state  <= LOCKED;
                                    r_locked <= 1'b1;
                                end
                            end
                        end
                        default: begin
                            r_err_step <= 1'b1;
                            r_state    <= TRACK;
                            r_run      <= 4'd0;
                            r_index    <= w_index;
                            r_locked   <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign index    = r_index;
    assign dir      = r_dir;
    assign locked   = r_locked;
    assign err_code = r_err_code;
    assign err_step = r_err_step;
    assign lap      = r_lap;

endmodule
`default_nettype wire

// File: tb/tb_skip_seq_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_skip_seq_decoder
// Brief    : Directed self-checking bench for skip_seq_decoder (LOCK_LEN=3).
// Revision : 1.0  initial release
// ============================================================================
module tb_skip_seq_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid;
    logic [3:0] code;
    logic [3:0] index;
    logic       dir;
    logic       locked;
    logic       err_code;
    logic       err_step;
    logic [7:0] lap;

    int n_checks = 0;
    int n_pass   = 0;
    int n_vec    = 0;

    skip_seq_decoder #(.LOCK_LEN(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .valid    (valid),
        .code     (code),
        .index    (index),
        .dir      (dir),
        .locked   (locked),
        .err_code (err_code),
        .err_step (err_step),
        .lap      (lap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_all(input logic [3:0] ei, input logic ed, input logic el,
                             input logic eec, input logic ees, input logic [7:0] elap);
        check($sformatf("v%0d.index", n_vec), 32'(index), 32'(ei));
        check($sformatf("v%0d.dir", n_vec), 32'(dir), 32'(ed));
        check($sformatf("v%0d.locked", n_vec), 32'(locked), 32'(el));
        check($sformatf("v%0d.err_code", n_vec), 32'(err_code), 32'(eec));
        check($sformatf("v%0d.err_step", n_vec), 32'(err_step), 32'(ees));
        check($sformatf("v%0d.lap", n_vec), 32'(lap), 32'(elap));
    endtask

    // One clock of stimulus followed by a full output check 1ns after the edge.
    task automatic apply(input logic v, input logic [3:0] c, input logic [3:0] ei,
                         input logic ed, input logic el, input logic eec,
                         input logic ees, input logic [7:0] elap);
        valid = v;
        code  = c;
        @(posedge clk);
        #1;
        n_vec++;
        check_all(ei, ed, el, eec, ees, elap);
    endtask

    task automatic drive(input logic [3:0] c);
        valid = 1'b1;
        code  = c;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] lap_codes [12];

    initial begin
        lap_codes = '{4'd13, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                      4'd8, 4'd9, 4'd11, 4'd12};
        reset = 1'b1;
        valid = 1'b0;
        code  = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check_all(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        reset = 1'b0;

        // Up sequence: lock on the sample of code 3, lap +1 at 13->0.
        apply(1, 4'd0,  4'd0,  1, 0, 0, 0, 8'h00);
        apply(1, 4'd1,  4'd1,  1, 0, 0, 0, 8'h00);
        apply(1, 4'd2,  4'd2,  1, 0, 0, 0, 8'h00);
        apply(1, 4'd3,  4'd3,  1, 1, 0, 0, 8'h00);
        apply(1, 4'd4,  4'd4,  1, 1, 0, 0, 8'h00);
        apply(1, 4'd5,  4'd5,  1, 1, 0, 0, 8'h00);
        apply(1, 4'd6,  4'd6,  1, 1, 0, 0, 8'h00);
        apply(1, 4'd8,  4'd7,  1, 1, 0, 0, 8'h00);
        apply(1, 4'd9,  4'd8,  1, 1, 0, 0, 8'h00);
        apply(1, 4'd11, 4'd9,  1, 1, 0, 0, 8'h00);
        apply(1, 4'd12, 4'd10, 1, 1, 0, 0, 8'h00);
        apply(1, 4'd13, 4'd11, 1, 1, 0, 0, 8'h00);
        apply(1, 4'd0,  4'd0,  1, 1, 0, 0, 8'h01);

        // Reversal while locked, then down through the skips and past 0.
        apply(1, 4'd13, 4'd11, 0, 1, 0, 0, 8'h00);
        apply(1, 4'd12, 4'd10, 0, 1, 0, 0, 8'h00);
        apply(1, 4'd11, 4'd9,  0, 1, 0, 0, 8'h00);
        apply(1, 4'd9,  4'd8,  0, 1, 0, 0, 8'h00);
        apply(1, 4'd8,  4'd7,  0, 1, 0, 0, 8'h00);
        apply(1, 4'd6,  4'd6,  0, 1, 0, 0, 8'h00);
        apply(1, 4'd5,  4'd5,  0, 1, 0, 0, 8'h00);
        apply(1, 4'd4,  4'd4,  0, 1, 0, 0, 8'h00);
        apply(1, 4'd3,  4'd3,  0, 1, 0, 0, 8'h00);
        apply(1, 4'd2,  4'd2,  0, 1, 0, 0, 8'h00);
        apply(1, 4'd1,  4'd1,  0, 1, 0, 0, 8'h00);
        apply(1, 4'd0,  4'd0,  0, 1, 0, 0, 8'h00);
        apply(1, 4'd13, 4'd11, 0, 1, 0, 0, 8'hFF);

        // Illegal code while locked, then re-acquire at 5.
        apply(1, 4'd7,  4'd11, 0, 0, 1, 0, 8'hFF);
        apply(1, 4'd5,  4'd5,  0, 0, 0, 0, 8'hFF);
        apply(1, 4'd4,  4'd4,  0, 0, 0, 0, 8'hFF);
        apply(1, 4'd3,  4'd3,  0, 0, 0, 0, 8'hFF);
        apply(1, 4'd2,  4'd2,  0, 1, 0, 0, 8'hFF);

        // Jump 2 -> 9 while locked, then three up steps relock.
        apply(1, 4'd9,  4'd8,  0, 0, 0, 1, 8'hFF);
        apply(1, 4'd11, 4'd9,  1, 0, 0, 0, 8'hFF);
        apply(1, 4'd12, 4'd10, 1, 0, 0, 0, 8'hFF);
        apply(1, 4'd13, 4'd11, 1, 1, 0, 0, 8'hFF);

        // Hold while locked, then jump to 4 and hold there: holds must not advance run.
        apply(1, 4'd13, 4'd11, 1, 1, 0, 0, 8'hFF);
        apply(1, 4'd4,  4'd4,  1, 0, 0, 1, 8'hFF);
        for (int i = 0; i < 4; i++)
            apply(1, 4'd4, 4'd4, 1, 0, 0, 0, 8'hFF);
        apply(1, 4'd5,  4'd5,  1, 0, 0, 0, 8'hFF);
        apply(1, 4'd6,  4'd6,  1, 0, 0, 0, 8'hFF);
        apply(1, 4'd8,  4'd7,  1, 1, 0, 0, 8'hFF);

        // valid low with an illegal code on the bus: everything frozen.
        apply(0, 4'd15, 4'd7,  1, 1, 0, 0, 8'hFF);
        apply(0, 4'd15, 4'd7,  1, 1, 0, 0, 8'hFF);

        // Back-to-back illegal codes keep err_code high; next legal code re-references.
        apply(1, 4'd14, 4'd7,  1, 0, 1, 0, 8'hFF);
        apply(1, 4'd15, 4'd7,  1, 0, 1, 0, 8'hFF);
        apply(1, 4'd10, 4'd7,  1, 0, 1, 0, 8'hFF);
        apply(1, 4'd8,  4'd7,  1, 0, 0, 0, 8'hFF);
        apply(1, 4'd9,  4'd8,  1, 0, 0, 0, 8'hFF);
        apply(1, 4'd11, 4'd9,  1, 0, 0, 0, 8'hFF);
        apply(1, 4'd12, 4'd10, 1, 1, 0, 0, 8'hFF);

        // 128 up laps from -1 reach +127; one more wraps to -128.
        for (int r = 0; r < 128; r++)
            for (int k = 0; k < 12; k++)
                drive(lap_codes[k]);
        n_vec++;
        check_all(4'd10, 1'b1, 1'b1, 1'b0, 1'b0, 8'h7F);
        for (int k = 0; k < 12; k++)
            drive(lap_codes[k]);
        n_vec++;
        check_all(4'd10, 1'b1, 1'b1, 1'b0, 1'b0, 8'h80);

        // Reset wins over a valid illegal sample while locked.
        reset = 1'b1;
        apply(1, 4'd15, 4'd0,  1, 0, 0, 0, 8'h00);
        reset = 1'b0;
        // Reset left the tracker in IDLE, so a distant code is accepted without err_step.
        apply(1, 4'd5,  4'd5,  1, 0, 0, 0, 8'h00);
        valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/skip_seq_decoder.md
# skip_seq_decoder

Receive-side tracker for the 4-bit skip-sequence counter code: 0..13 with 7 and 10 never emitted, 12 legal values, up/down with wrap 13↔0. Samples the code stream on a strobe and converts each legal code to a dense ordinal index 0..11. Infers count direction, flags illegal codes and illegal jumps, and declares lock after a run of legal steps. Sits downstream of the counter, or of any link carrying its code, as the consumer and checker.

## Interface
- LOCK_LEN, 3: consecutive legal steps required to assert `locked` (1..15).
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- valid  in  1  sample strobe; `code` is consumed on cycles where `valid` is 1.
- code  in  4  counter code under observation.
- index  out  4  ordinal of the last accepted legal code (0..11).
- dir  out  1  last inferred direction: 1 is up, 0 is down.
- locked  out  1  tracker is locked to the sequence.
- err_code  out  1  one-cycle pulse: sampled code illegal (7, 10, 14, 15).
- err_step  out  1  one-cycle pulse: legal code that is neither a hold nor a neighbour step.
- lap  out  8  signed wrap count modulo 256.

## Operation
- Map: codes 0..6 → 0..6; 8, 9 → 7, 8; 11, 12, 13 → 9, 10, 11. All other codes are illegal.
- Step classification against the previous index p and the new index n:
  - n == p: hold.
  - n == (p+1) mod 12: up.
  - n == (p−1) mod 12: down.
  - Otherwise: jump.
- States:
  - IDLE: no reference sample.
  - TRACK: reference held; `run` counts legal steps, 0..LOCK_LEN.
  - LOCKED.
- IDLE + legal code → TRACK; index ← n; run ← 0; no error pulse.
- TRACK/LOCKED + hold → state unchanged; no error; run, dir and lap unchanged.
- TRACK + up/down → index ← n; dir updated; run+1; enter LOCKED when run+1 == LOCK_LEN.
- LOCKED + up/down → index ← n; dir updated. A direction reversal is legal and does not drop lock.
- Any state + illegal code → err_code; go to IDLE; locked ← 0; index, dir and lap hold.
- TRACK/LOCKED + jump → err_step; go to TRACK with run ← 0; index ← n; locked ← 0; dir and lap hold.
- IDLE + jump is impossible, because IDLE has no reference.
- lap:
  - +1 on an up step 11→0 (code 13→0).
  - −1 on a down step 0→11.
  - Counted in TRACK and LOCKED only.
  - Wraps two's-complement: 127+1 = −128.
- `valid` = 0: everything holds; error pulses deassert.

## Timing
- All outputs are registered. A sample accepted at edge k is reflected in the outputs after edge k, i.e. one-cycle latency.
- err_code and err_step:
  - High for exactly the one cycle following the offending sample.
  - Back-to-back offending samples give continuous high.
  - Never both high together.
- Reset values: index 0, dir 1, locked 0, err_code 0, err_step 0, lap 0, state IDLE, run 0.
- Reset has priority over `valid` on the same edge. Reset mid-lock drops to IDLE on that edge.
- `locked` rises on the edge that accepts the LOCK_LEN-th consecutive legal step after the reference.

## Structure
- Package `skip_seq_pkg`:
  - Code constants CODE_MAX = 13 and SKIP_A/SKIP_B = 7/10.
  - NUM_IDX = 12.
  - State enum {IDLE, TRACK, LOCKED}.
  - Step enum {HOLD, UP, DOWN, JUMP}.
- Sub-module `skip_code_map`: combinational code → {legal, index[3:0]}.
- Top holds the FSM, step classifier, run counter and lap register.

## Test plan
- Reset, then up sequence 0,1,…,6,8,9,11,12,13,0 with LOCK_LEN=3 → index 0..11 then 0. locked high after the sample of code 3. dir=1. lap=1. No errors.
- Locked at code 8, then feed 6 → down step: index 6, dir 0, locked stays 1. Then 13→0 reversal sequence down from 0 → 13: lap −1 (8'hFF).
- Locked, feed 7 → err_code pulse for one cycle; locked 0; index holds. Next code 5 → TRACK, index 5, no pulse.
- Locked at code 2, feed 9 → err_step pulse; locked 0; index 8. Three further up steps (11, 12, 13) relock.
- Hold and idle check: code 4 repeated ×5 → no error, run unchanged. `valid` low with code 15 on the bus → no pulse, outputs frozen.
- Reset asserted together with `valid` and code 15 while locked → next cycle all reset values, no err_code.
